// File: rtl/reset_sequencer.sv
// Board-level reset generator: merges POR, PLL lock, debounced key and software
// request into NCH active-high resets released in ascending order after a hold.
module reset_sequencer #(
   parameter int NCH             = 3,
   parameter int HOLD_CYCLES     = 1024,
   parameter int STAGGER_CYCLES  = 16,
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int KEY_ACTIVE_LOW  = 1,
   parameter int SYNC_STAGES     = 2
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           pll_locked,
   input  logic           key,
   input  logic           sw_reset_req,
   input  logic           cause_clr,
   output logic [NCH-1:0] rst_o,
   output logic [NCH-1:0] rst_n_o,
   output logic           busy,
   output logic [2:0]     cause_o
);

   if (NCH < 1 || HOLD_CYCLES < 1 || STAGGER_CYCLES < 1 ||
       DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_param_check
      $fatal(1, "reset_sequencer: illegal parameter value");
   end

   localparam logic [1:0] S_ASSERT  = 2'd0;
   localparam logic [1:0] S_HOLD    = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;
   localparam logic [1:0] S_RUN     = 2'd3;

   localparam logic KEY_IDLE = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int DBW     = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0]  STAG_LAST = CW'(STAGGER_CYCLES - 1);
   localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] pll_sync_q;
   logic [SYNC_STAGES-1:0] key_sync_q;
   logic                   pll_sync;
   logic                   key_pressed_sync;

   logic [DBW-1:0] db_cnt;
   logic           key_db;
   logic           key_accept;
   logic           key_db_next;

   logic [1:0]     state;
   logic [CW-1:0]  cnt;
   logic [NCH-1:0] rst_q;
   logic [NCH-1:0] rst_shift;
   logic           seen_run;
   logic           src;

   logic           cause_en;
   logic [2:0]     cause_set;
   logic [2:0]     cause_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pll_sync_q <= '0;
         key_sync_q <= {SYNC_STAGES{KEY_IDLE}};
      end else begin
         pll_sync_q <= {pll_sync_q[SYNC_STAGES-2:0], pll_locked};
         key_sync_q <= {key_sync_q[SYNC_STAGES-2:0], key};
      end
   end

   assign pll_sync         = pll_sync_q[SYNC_STAGES-1];
   assign key_pressed_sync = key_sync_q[SYNC_STAGES-1] ^ KEY_IDLE;

   assign key_accept  = (key_pressed_sync != key_db) && (db_cnt == DB_LAST);
   assign key_db_next = key_accept ? key_pressed_sync : key_db;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         db_cnt <= '0;
         key_db <= 1'b0;
      end else if (key_pressed_sync == key_db || key_accept) begin
         db_cnt <= '0;
         key_db <= key_db_next;
      end else begin
         db_cnt <= db_cnt + DBW'(1);
      end
   end

   assign src = ~pll_sync | key_db | sw_reset_req;

   // Channels release in ascending order, so a left shift of the all-ones
   // vector clears exactly the next channel; the sequence ends when it is empty.
   assign rst_shift = rst_q << 1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= S_ASSERT;
         cnt      <= '0;
         rst_q    <= '1;
         seen_run <= 1'b0;
      end else if (src) begin
         state <= S_ASSERT;
         cnt   <= '0;
         rst_q <= '1;
      end else begin
         case (state)
            S_ASSERT: begin
               state <= S_HOLD;
               cnt   <= '0;
            end
            S_HOLD, S_RELEASE: begin
               if (cnt == ((state == S_HOLD) ? HOLD_LAST : STAG_LAST)) begin
                  cnt   <= '0;
                  rst_q <= rst_shift;
                  if (rst_shift == '0) begin
                     state    <= S_RUN;
                     seen_run <= 1'b1;
                  end else begin
                     state <= S_RELEASE;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               cnt <= '0;
            end
         endcase
      end
   end

   // PLL loss only counts once a full sequence has completed; the other
   // causes also count once the FSM has left ASSERT for the first time.
   assign cause_en  = (state != S_ASSERT) || seen_run;
   assign cause_set = {sw_reset_req & cause_en, ~pll_sync & seen_run, key_db_next & cause_en};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cause_q <= '0;
      end else begin
         cause_q <= (cause_clr ? 3'b000 : cause_q) | cause_set;
      end
   end

   assign rst_o   = rst_q;
   assign rst_n_o = ~rst_q;
   assign busy    = |rst_q;
   assign cause_o = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: timeline-based reference model,
// directed scenarios and randomized key/PLL/software/clear activity.
module tb_reset_sequencer;

   localparam int NCH  = 3;
   localparam int HOLD = 8;
   localparam int STAG = 4;
   localparam int DEB  = 16;
   localparam int SYNC = 2;
   localparam bit KEY_LOW = 1'b1;
   localparam logic KEY_IDLE  = KEY_LOW ? 1'b1 : 1'b0;
   localparam logic KEY_PRESS = ~KEY_IDLE;

   logic           clock = 1'b0;
   logic           reset;
   logic           pll_locked;
   logic           key;
   logic           sw_reset_req;
   logic           cause_clr;
   logic [NCH-1:0] rst_o;
   logic [NCH-1:0] rst_n_o;
   logic           busy;
   logic [2:0]     cause_o;

   reset_sequencer #(
      .NCH             (NCH),
      .HOLD_CYCLES     (HOLD),
      .STAGGER_CYCLES  (STAG),
      .DEBOUNCE_CYCLES (DEB),
      .KEY_ACTIVE_LOW  (1),
      .SYNC_STAGES     (SYNC)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .pll_locked   (pll_locked),
      .key          (key),
      .sw_reset_req (sw_reset_req),
      .cause_clr    (cause_clr),
      .rst_o        (rst_o),
      .rst_n_o      (rst_n_o),
      .busy         (busy),
      .cause_o      (cause_o)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: sampled-input history, sliding debounce window and a
   // release timeline anchored at T0 (the edge at which all sources went quiet).
   int       edge_n;
   bit       pll_hist[$];
   bit       key_hist[$];
   bit       ks_hist[$];
   bit       m_key_db;
   bit       m_asserting;
   int       m_t0;
   bit       m_seen_run;
   bit [2:0] m_cause;
   bit [NCH-1:0] m_rst;
   int       fall_at[NCH];

   function automatic bit pressed(input logic k);
      return KEY_LOW ? (k == 1'b0) : (k == 1'b1);
   endfunction

   function automatic void model_reset();
      pll_hist.delete();
      key_hist.delete();
      ks_hist.delete();
      edge_n      = 0;
      m_key_db    = 1'b0;
      m_asserting = 1'b1;
      m_t0        = 0;
      m_seen_run  = 1'b0;
      m_cause     = 3'b000;
      m_rst       = '1;
      foreach (fall_at[i]) fall_at[i] = -1;
   endfunction

   function automatic void model_edge();
      bit p_s, k_s, src, db_next, all_diff, en;
      bit [2:0] set;
      p_s = (edge_n >= SYNC) ? pll_hist[edge_n-SYNC] : 1'b0;
      k_s = (edge_n >= SYNC) ? key_hist[edge_n-SYNC] : 1'b0;
      pll_hist.push_back(pll_locked == 1'b1);
      key_hist.push_back(pressed(key));
      ks_hist.push_back(k_s);
      db_next = m_key_db;
      if (edge_n >= DEB-1) begin
         all_diff = 1'b1;
         for (int e = edge_n-DEB+1; e <= edge_n; e++)
            if (ks_hist[e] == m_key_db) all_diff = 1'b0;
         if (all_diff) db_next = !m_key_db;
      end
      src = !p_s || m_key_db || (sw_reset_req == 1'b1);
      en  = !m_asserting || m_seen_run;
      set = {(sw_reset_req == 1'b1) && en, !p_s && m_seen_run, db_next && en};
      m_cause = ((cause_clr == 1'b1) ? 3'b000 : m_cause) | set;
      if (src) m_asserting = 1'b1;
      else if (m_asserting) begin
         m_asserting = 1'b0;
         m_t0        = edge_n;
      end
      for (int i = 0; i < NCH; i++)
         m_rst[i] = m_asserting || (edge_n < m_t0 + HOLD + i*STAG);
      if (m_rst == '0) m_seen_run = 1'b1;
      m_key_db = db_next;
      edge_n++;
   endfunction

   task automatic cycle();
      logic [NCH-1:0] dprev;
      logic [NCH-1:0] exp_n;
      dprev = rst_o;
      model_edge();
      @(posedge clock);
      #1;
      for (int i = 0; i < NCH; i++)
         if (dprev[i] && !rst_o[i] && fall_at[i] < 0) fall_at[i] = edge_n - 1;
      exp_n = ~m_rst;
      check("rst_o", rst_o, m_rst);
      check("rst_n_o", rst_n_o, exp_n);
      check("busy", busy, |m_rst);
      check("cause_o", cause_o, m_cause);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic check_in_reset(input string tag);
      check({tag, "_rst_o"}, rst_o, 3'b111);
      check({tag, "_rst_n_o"}, rst_n_o, 3'b000);
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_cause"}, cause_o, 3'b000);
   endtask

   task automatic pulse_sw();
      sw_reset_req = 1'b1;
      cycle();
      sw_reset_req = 1'b0;
   endtask

   task automatic pulse_clr();
      cause_clr = 1'b1;
      cycle();
      cause_clr = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      pll_locked   = 1'b1;
      key          = KEY_IDLE;
      sw_reset_req = 1'b0;
      cause_clr    = 1'b0;
      model_reset();
      #2;
      check_in_reset("por_start");
      repeat (5) begin
         @(posedge clock);
         #1;
         check_in_reset("por_hold");
      end
      reset = 1'b0;
      model_reset();

      // Power-on: T0 is edge 2 (two synchroniser edges), releases at +8/+12/+16
      cycles(25);
      check("por_fall0", fall_at[0], 10);
      check("por_fall1", fall_at[1], 14);
      check("por_fall2", fall_at[2], 18);
      check("por_cause", cause_o, 3'b000);

      // Key bounce shorter than the debounce window, then a real press
      repeat (3) begin
         key = KEY_PRESS;
         cycles(5);
         key = KEY_IDLE;
         cycles(10);
      end
      check("bounce_rst", rst_o, 3'b000);
      key = KEY_PRESS;
      cycles(20);
      check("key_rst", rst_o, 3'b111);
      key = KEY_IDLE;
      cycles(60);
      check("key_cause", cause_o, 3'b001);

      // Clear alone, then clear coinciding with key acceptance (edge 17 after press)
      pulse_clr();
      check("clr_alone", cause_o, 3'b000);
      key = KEY_PRESS;
      cycles(17);
      cause_clr = 1'b1;
      cycle();
      cause_clr = 1'b0;
      check("clr_vs_set", cause_o[0], 1'b1);
      cycles(3);
      key = KEY_IDLE;
      cycles(60);

      // Software reset from RUN
      pulse_clr();
      pulse_sw();
      cycles(25);
      check("sw_cause", cause_o, 3'b100);

      // PLL loss while channel 0 is already released
      pulse_sw();
      for (int i = 0; i < 40 && rst_o !== 3'b110; i++) cycle();
      check("wait_110", rst_o, 3'b110);
      pll_locked = 1'b0;
      cycles(3);
      pll_locked = 1'b1;
      cycles(30);
      check("pll_cause", cause_o[1], 1'b1);

      // Asynchronous reset in the middle of HOLD, between edges
      pulse_sw();
      cycles(4);
      #2;
      reset = 1'b1;
      #1;
      check_in_reset("async");
      model_reset();
      repeat (2) begin
         @(posedge clock);
         #1;
         check_in_reset("async_hold");
      end
      reset = 1'b0;
      model_reset();
      cycles(25);
      check("async_fall0", fall_at[0], 10);
      check("async_fall2", fall_at[2], 18);

      // Randomized activity against the reference model
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 5))
            0: begin
               key = KEY_PRESS;
               cycles($urandom_range(1, DEB-4));
               key = KEY_IDLE;
               cycles($urandom_range(1, 10));
            end
            1: begin
               key = KEY_PRESS;
               cycles($urandom_range(14, 35));
               key = KEY_IDLE;
               cycles($urandom_range(10, 50));
            end
            2: begin
               pll_locked = 1'b0;
               cycles($urandom_range(1, 6));
               pll_locked = 1'b1;
               cycles($urandom_range(0, 30));
            end
            3: pulse_sw();
            4: pulse_clr();
            default: cycles($urandom_range(0, 30));
         endcase
      end
      cycles(60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
